versat_split: RTL and testbench

//  Stream demultiplexer; inverse of the round-robin merge unit. After a programmable start delay,

---
 rtl/versat_split_pkg.sv | 22 ++
 rtl/versat_delay_cnt.sv | 34 +++
 rtl/versat_split.sv | 156 +++++++++++++++
 tb/tb_versat_split.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/versat_split_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : versat_split_pkg
//  Description : Shared state encodings, lane geometry and helpers for the
//                round-robin stream splitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package versat_split_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_SPLIT = 2'd2;

    localparam int NUM_LANES = 16;
    localparam int LANE_W    = 4;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
        return NUM_LANES'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/versat_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : versat_delay_cnt
//  Description : Loadable down-counter that stops at zero and flags it; used
//                to hold off the start of delayed-start units.
//  Revision    : 1.0 - initial release
// ============================================================================
module versat_delay_cnt #(
    parameter int DELAY_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [DELAY_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [DELAY_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DELAY_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/versat_split.sv
`default_nettype none
// ============================================================================
//  Module      : versat_split
//  Description : Stream demultiplexer. After a programmable start delay, steers
//                one in0 word per enabled cycle to out0..out15 round-robin,
//                optionally stopping after a programmed word count.
//  Config      : VERSAT_SPLIT_VALID_EN adds the per-lane 'valid' strobe port.
//  Revision    : 1.0 - initial release
// ============================================================================
module versat_split
    import versat_split_pkg::*;
#(
    parameter int DELAY_W  = 32,
    parameter int DATA_W   = 32,
    parameter int AMOUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 running,
    input  logic [DATA_W-1:0]    in0,
    output logic [DATA_W-1:0]    out0,
    output logic [DATA_W-1:0]    out1,
    output logic [DATA_W-1:0]    out2,
    output logic [DATA_W-1:0]    out3,
    output logic [DATA_W-1:0]    out4,
    output logic [DATA_W-1:0]    out5,
    output logic [DATA_W-1:0]    out6,
    output logic [DATA_W-1:0]    out7,
    output logic [DATA_W-1:0]    out8,
    output logic [DATA_W-1:0]    out9,
    output logic [DATA_W-1:0]    out10,
    output logic [DATA_W-1:0]    out11,
    output logic [DATA_W-1:0]    out12,
    output logic [DATA_W-1:0]    out13,
    output logic [DATA_W-1:0]    out14,
    output logic [DATA_W-1:0]    out15,
`ifdef VERSAT_SPLIT_VALID_EN
    output logic [NUM_LANES-1:0] valid,
`endif
    output logic                 done,
    input  logic [DELAY_W-1:0]   delay0,
    input  logic [AMOUNT_W-1:0]  amount0
);

    logic [1:0]          state_q,  state_d;
    logic [LANE_W-1:0]   cnt_q,    cnt_d;
    logic [AMOUNT_W-1:0] rem_q,    rem_d;
    logic [DATA_W-1:0]   lanes_q [NUM_LANES];
    logic                capture;
    logic                delay_zero;
    logic                delay_en;

    assign delay_en = (state_q == ST_WAIT) && running && !run;

    versat_delay_cnt #(
        .DELAY_W    (DELAY_W)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .load_i     (run),
        .en_i       (delay_en),
        .load_val_i (delay0),
        .zero_o     (delay_zero)
    );

    // rem_q == 0 while splitting marks an unbounded run; a bounded run leaves
    // SPLIT on the capture where rem_q is 1, so it never reaches 0 there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        capture = 1'b0;
        if (run) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            rem_d   = amount0;
        end else if (running) begin
            case (state_q)
                ST_WAIT: begin
                    if (delay_zero) begin
                        state_d = ST_SPLIT;
                    end
                end
                ST_SPLIT: begin
                    capture = 1'b1;
                    cnt_d   = cnt_q + LANE_W'(1);
                    if (rem_q != '0) begin
                        rem_d = rem_q - AMOUNT_W'(1);
                        if (rem_q == AMOUNT_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else if (capture) begin
            lanes_q[cnt_q] <= in0;
        end
    end

`ifdef VERSAT_SPLIT_VALID_EN
    logic [NUM_LANES-1:0] valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= capture ? lane_onehot(cnt_q) : '0;
        end
    end

    assign valid = valid_q;
`endif

    assign done  = (state_q == ST_IDLE);

    assign out0  = lanes_q[0];
    assign out1  = lanes_q[1];
    assign out2  = lanes_q[2];
    assign out3  = lanes_q[3];
    assign out4  = lanes_q[4];
    assign out5  = lanes_q[5];
    assign out6  = lanes_q[6];
    assign out7  = lanes_q[7];
    assign out8  = lanes_q[8];
    assign out9  = lanes_q[9];
    assign out10 = lanes_q[10];
    assign out11 = lanes_q[11];
    assign out12 = lanes_q[12];
    assign out13 = lanes_q[13];
    assign out14 = lanes_q[14];
    assign out15 = lanes_q[15];

endmodule
`default_nettype wire

// File: tb/tb_versat_split.sv
`default_nettype none
// ============================================================================
//  Module      : tb_versat_split
//  Description : Self-checking bench for versat_split against a schedule-level
//                reference model (active cycles since run, words captured).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_versat_split;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        running;
    logic [31:0] in0;
    logic [31:0] delay0;
    logic [15:0] amount0;
    logic        done;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [31:0] out8, out9, out10, out11, out12, out13, out14, out15;
    logic [31:0] dut_out [16];
`ifdef VERSAT_SPLIT_VALID_EN
    logic [15:0] valid;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: a run makes the unit busy; the capture schedule is
    // "active cycle number >= delay+2", lane = words captured mod 16.
    bit          m_busy;
    longint      m_active;
    int          m_cap;
    int          m_d;
    int          m_amt;
    logic [31:0] m_lane [16];
    logic [15:0] m_valid;

    versat_split dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .running (running),
        .in0     (in0),
        .out0    (out0),  .out1  (out1),  .out2  (out2),  .out3  (out3),
        .out4    (out4),  .out5  (out5),  .out6  (out6),  .out7  (out7),
        .out8    (out8),  .out9  (out9),  .out10 (out10), .out11 (out11),
        .out12   (out12), .out13 (out13), .out14 (out14), .out15 (out15),
`ifdef VERSAT_SPLIT_VALID_EN
        .valid   (valid),
`endif
        .done    (done),
        .delay0  (delay0),
        .amount0 (amount0)
    );

    assign dut_out[0]  = out0;   assign dut_out[1]  = out1;
    assign dut_out[2]  = out2;   assign dut_out[3]  = out3;
    assign dut_out[4]  = out4;   assign dut_out[5]  = out5;
    assign dut_out[6]  = out6;   assign dut_out[7]  = out7;
    assign dut_out[8]  = out8;   assign dut_out[9]  = out9;
    assign dut_out[10] = out10;  assign dut_out[11] = out11;
    assign dut_out[12] = out12;  assign dut_out[13] = out13;
    assign dut_out[14] = out14;  assign dut_out[15] = out15;

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy   = 1'b0;
        m_active = 0;
        m_cap    = 0;
        m_d      = 0;
        m_amt    = 0;
        m_valid  = '0;
        for (int l = 0; l < 16; l++) m_lane[l] = '0;
    endtask

    // One clock: drive at negedge, advance model on posedge, settle 1 time unit.
    task automatic tick(input bit r, input bit en);
        @(negedge clk);
        run     = r;
        running = en;
        in0     = $urandom;
        @(posedge clk);
        if (r) begin
            m_busy   = 1'b1;
            m_active = 0;
            m_cap    = 0;
            m_d      = int'(delay0);
            m_amt    = int'(amount0);
            m_valid  = '0;
        end else if (en && m_busy) begin
            m_active++;
            if (m_active >= longint'(m_d) + 2) begin
                m_lane[m_cap % 16] = in0;
                m_valid = 16'(1) << (m_cap % 16);
                m_cap++;
                if (m_amt != 0 && m_cap == m_amt) m_busy = 1'b0;
            end else begin
                m_valid = '0;
            end
        end else begin
            m_valid = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        running = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; running = 1'b0; in0 = '0; delay0 = '0; amount0 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL reset_done: got %b want 1", done); end
        for (int l = 0; l < 16; l++) begin
            tests++;
            if (dut_out[l] !== 32'h0) begin
                fails++; $display("FAIL reset_lane%0d: got %h want 0", l, dut_out[l]);
            end
        end
`ifdef VERSAT_SPLIT_VALID_EN
        tests++;
        if (valid !== 16'h0) begin fails++; $display("FAIL reset_valid: got %h want 0", valid); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full16();
        do_reset();
        delay0 = 0; amount0 = 16;
        for (int c = 0; c < 22; c++) begin
            tick(c == 0, 1'b1);
            tests++;
            if (done !== !m_busy) begin fails++; $display("FAIL full16_done c%0d: got %b want %b", c, done, !m_busy); end
            for (int l = 0; l < 16; l++) begin
                tests++;
                if (dut_out[l] !== m_lane[l]) begin
                    fails++; $display("FAIL full16_lane%0d c%0d: got %h want %h", l, c, dut_out[l], m_lane[l]);
                end
            end
        end
    endtask

    task automatic test_delay();
        do_reset();
        delay0 = 3; amount0 = 4;
        for (int c = 0; c < 12; c++) begin
            tick(c == 0, 1'b1);
            tests++;
            if (done !== !m_busy) begin fails++; $display("FAIL delay_done c%0d: got %b want %b", c, done, !m_busy); end
            for (int l = 0; l < 16; l++) begin
                tests++;
                if (dut_out[l] !== m_lane[l]) begin
                    fails++; $display("FAIL delay_lane%0d c%0d: got %h want %h", l, c, dut_out[l], m_lane[l]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        delay0 = 0; amount0 = 20;
        for (int c = 0; c < 26; c++) begin
            tick(c == 0, 1'b1);
            tests++;
            if (done !== !m_busy) begin fails++; $display("FAIL wrap_done c%0d: got %b want %b", c, done, !m_busy); end
            for (int l = 0; l < 16; l++) begin
                tests++;
                if (dut_out[l] !== m_lane[l]) begin
                    fails++; $display("FAIL wrap_lane%0d c%0d: got %h want %h", l, c, dut_out[l], m_lane[l]);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        delay0 = 1; amount0 = 10;
        for (int c = 0; c < 20; c++) begin
            tick(c == 0, !(c >= 6 && c <= 8));
            tests++;
            if (done !== !m_busy) begin fails++; $display("FAIL stall_done c%0d: got %b want %b", c, done, !m_busy); end
            for (int l = 0; l < 16; l++) begin
                tests++;
                if (dut_out[l] !== m_lane[l]) begin
                    fails++; $display("FAIL stall_lane%0d c%0d: got %h want %h", l, c, dut_out[l], m_lane[l]);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        int guard;
        do_reset();
        delay0 = 0; amount0 = 0;
        tick(1'b1, 1'b1);
        guard = 0;
        while (m_cap < 5 && guard < 50) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        tests++;
        if (guard >= 50) begin fails++; $display("FAIL rstmid_timeout: got %0d words want 5", m_cap); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL rstmid_done: got %b want 1", done); end
        for (int l = 0; l < 16; l++) begin
            tests++;
            if (dut_out[l] !== 32'h0) begin
                fails++; $display("FAIL rstmid_lane%0d: got %h want 0", l, dut_out[l]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        delay0 = 1; amount0 = 3;
        for (int c = 0; c < 8; c++) begin
            tick(c == 0, 1'b1);
            tests++;
            if (done !== !m_busy) begin fails++; $display("FAIL restart_done c%0d: got %b want %b", c, done, !m_busy); end
            for (int l = 0; l < 16; l++) begin
                tests++;
                if (dut_out[l] !== m_lane[l]) begin
                    fails++; $display("FAIL restart_lane%0d c%0d: got %h want %h", l, c, dut_out[l], m_lane[l]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int e = 0; e < 8; e++) begin
            delay0  = $urandom_range(0, 4);
            amount0 = 16'($urandom_range(0, 24));
            for (int c = 0; c < 40; c++) begin
                tick(c == 0 || ($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0);
                tests++;
                if (done !== !m_busy) begin fails++; $display("FAIL rand_done e%0d c%0d: got %b want %b", e, c, done, !m_busy); end
                for (int l = 0; l < 16; l++) begin
                    tests++;
                    if (dut_out[l] !== m_lane[l]) begin
                        fails++; $display("FAIL rand_lane%0d e%0d c%0d: got %h want %h", l, e, c, dut_out[l], m_lane[l]);
                    end
                end
`ifdef VERSAT_SPLIT_VALID_EN
                tests++;
                if (valid !== m_valid) begin fails++; $display("FAIL rand_valid e%0d c%0d: got %h want %h", e, c, valid, m_valid); end
`endif
            end
        end
    endtask

`ifdef VERSAT_SPLIT_VALID_EN
    task automatic test_valid();
        do_reset();
        delay0 = 0; amount0 = 2;
        for (int c = 0; c < 6; c++) begin
            tick(c == 0, 1'b1);
            tests++;
            if (valid !== m_valid) begin fails++; $display("FAIL valid_amt2 c%0d: got %h want %h", c, valid, m_valid); end
        end
        amount0 = 0;
        for (int c = 0; c < 14; c++) begin
            tick(c == 0 || c == 7, c != 4);
            tests++;
            if (valid !== m_valid) begin fails++; $display("FAIL valid_rerun c%0d: got %h want %h", c, valid, m_valid); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full16();
        test_delay();
        test_wrap();
        test_stall();
        test_rst_mid();
        test_random();
`ifdef VERSAT_SPLIT_VALID_EN
        test_valid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
